// File: rtl/fp16_operand_unpack.sv
// FP16 operand unpacker: turns binary16 words into sign, signed exponent,
// an 11-bit significand with an explicit leading one, and class flags.
// Subnormals are normalised one left shift per cycle, so the exponent lands
// on the same scale as the output packer: value = 1.sig * 2^(exp-15).
module fp16_operand_unpack #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [15:0]      i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_sign,
    output logic [6:0]       o_exp,
    output logic [10:0]      o_sig,
    output logic             o_zero,
    output logic             o_inf,
    output logic             o_nan,
    output logic [CNT_W-1:0] o_subnorm_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [6:0]         exp_q, exp_d;
    logic [10:0]        sig_q, sig_d;
    logic               zero_q, zero_d;
    logic               inf_q, inf_d;
    logic               nan_q, nan_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [4:0]         exp_field;
    logic [9:0]         frac_field;

    assign exp_field  = i_data[14:10];
    assign frac_field = i_data[9:0];

    // A new word can be taken when idle, or when the held result leaves this cycle.
    assign i_ready = (state_q == IDLE) || ((state_q == OUT) && o_ready);
    assign accept  = i_valid && i_ready;

    // Next-state logic: decode on accept, shift while normalising, drain on o_ready.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        cnt_d   = cnt_q;

        if (state_q == NORM) begin
            // Leading one already in place: nothing left to shift.
            if (sig_q[10]) begin
                state_d = OUT;
            end else begin
                sig_d = {sig_q[9:0], 1'b0};
                exp_d = exp_q - 7'd1;
                // The shifted value carries bit 10 exactly when bit 9 was set now.
                if (sig_q[9]) begin
                    state_d = OUT;
                end
            end
        end else if (accept) begin
            sign_d  = i_data[15];
            zero_d  = 1'b0;
            inf_d   = 1'b0;
            nan_d   = 1'b0;
            state_d = OUT;
            if (exp_field == 5'd0) begin
                if (frac_field == 10'd0) begin
                    zero_d = 1'b1;
                    exp_d  = 7'd0;
                    sig_d  = 11'd0;
                end else begin
                    // Subnormal: start at exponent +1 and let NORM walk it down.
                    sig_d   = {1'b0, frac_field};
                    exp_d   = 7'd1;
                    state_d = NORM;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else if (exp_field == 5'd31) begin
                exp_d = 7'd31;
                if (frac_field == 10'd0) begin
                    inf_d = 1'b1;
                    sig_d = {1'b1, 10'd0};
                end else begin
                    nan_d = 1'b1;
                    sig_d = {1'b1, frac_field};
                end
            end else begin
                exp_d = {2'b00, exp_field};
                sig_d = {1'b1, frac_field};
            end
        end else if ((state_q == OUT) && o_ready) begin
            state_d = IDLE;
        end
    end

    // State and working registers; reset discards any word in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 7'd0;
            sig_q   <= 11'd0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid       = (state_q == OUT);
    assign o_sign        = sign_q;
    assign o_exp         = exp_q;
    assign o_sig         = sig_q;
    assign o_zero        = zero_q;
    assign o_inf         = inf_q;
    assign o_nan         = nan_q;
    assign o_subnorm_cnt = cnt_q;

endmodule

// File: tb/tb_fp16_operand_unpack.sv
// Directed bench for fp16_operand_unpack. A second instance with a 3-bit
// counter shares every input so counter saturation is reachable quickly.
module tb_fp16_operand_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;

    logic        i_ready, o_valid, o_sign, o_zero, o_inf, o_nan;
    logic [6:0]  o_exp;
    logic [10:0] o_sig;
    logic [15:0] o_cnt;

    logic        sm_i_ready, sm_o_valid, sm_o_sign, sm_o_zero, sm_o_inf, sm_o_nan;
    logic [6:0]  sm_o_exp;
    logic [10:0] sm_o_sig;
    logic [2:0]  sm_o_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp16_operand_unpack #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig), .o_zero(o_zero),
        .o_inf(o_inf), .o_nan(o_nan), .o_subnorm_cnt(o_cnt)
    );

    fp16_operand_unpack #(.CNT_W(3)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_ready(sm_i_ready),
        .i_data(i_data), .o_valid(sm_o_valid), .o_ready(o_ready),
        .o_sign(sm_o_sign), .o_exp(sm_o_exp), .o_sig(sm_o_sig), .o_zero(sm_o_zero),
        .o_inf(sm_o_inf), .o_nan(sm_o_nan), .o_subnorm_cnt(sm_o_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic s, input logic [6:0] e,
                             input logic [10:0] m, input logic z, input logic inf, input logic nan);
        check_eq({tag, ".valid"}, 32'(o_valid), 32'd1);
        check_eq({tag, ".sign"},  32'(o_sign),  32'(s));
        check_eq({tag, ".exp"},   32'(o_exp),   32'(e));
        check_eq({tag, ".sig"},   32'(o_sig),   32'(m));
        check_eq({tag, ".zero"},  32'(o_zero),  32'(z));
        check_eq({tag, ".inf"},   32'(o_inf),   32'(inf));
        check_eq({tag, ".nan"},   32'(o_nan),   32'(nan));
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = 16'h0000; o_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("rst.valid", 32'(o_valid), 32'd0);
        check_eq("rst.exp",   32'(o_exp),   32'd0);
        check_eq("rst.sig",   32'(o_sig),   32'd0);
        check_eq("rst.flags", 32'({o_sign, o_zero, o_inf, o_nan}), 32'd0);
        check_eq("rst.cnt",   32'(o_cnt),   32'd0);
        check_eq("rst.ready", 32'(i_ready), 32'd1);

        // Back-to-back normals: 1.0 then -5.0, no bubble.
        o_ready = 1'b1; i_valid = 1'b1; i_data = 16'h3C00;
        tick();
        check_out("one", 1'b0, 7'd15, 11'h400, 1'b0, 1'b0, 1'b0);
        check_eq("one.ready", 32'(i_ready), 32'd1);
        i_data = 16'hC500;
        tick();
        check_out("m5", 1'b1, 7'd17, 11'h500, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        tick();
        check_eq("drain.valid", 32'(o_valid), 32'd0);

        // Minimum subnormal: ten normalising cycles, result on the eleventh.
        i_valid = 1'b1; i_data = 16'h0001;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("sub1.ready%0d", i), 32'(i_ready), 32'd0);
            check_eq($sformatf("sub1.valid%0d", i), 32'(o_valid), 32'd0);
            tick();
        end
        check_out("sub1", 1'b0, 7'h77, 11'h400, 1'b0, 1'b0, 1'b0);
        check_eq("sub1.cnt", 32'(o_cnt), 32'd1);

        // Subnormal 0x8200 (latency 2), then -0 straight after.
        i_valid = 1'b1; i_data = 16'h8200;
        tick();
        i_valid = 1'b0;
        check_eq("sub2.valid0", 32'(o_valid), 32'd0);
        tick();
        check_out("sub2", 1'b1, 7'd0, 11'h400, 1'b0, 1'b0, 1'b0);
        check_eq("sub2.cnt", 32'(o_cnt), 32'd2);
        i_valid = 1'b1; i_data = 16'h8000;
        tick();
        check_out("nzero", 1'b1, 7'd0, 11'h000, 1'b1, 1'b0, 1'b0);

        // Specials.
        i_data = 16'h7C00;
        tick();
        check_out("inf", 1'b0, 7'd31, 11'h400, 1'b0, 1'b1, 1'b0);
        i_data = 16'hFE00;
        tick();
        check_out("nan", 1'b1, 7'd31, 11'h600, 1'b0, 1'b0, 1'b1);
        i_valid = 1'b0;
        tick();
        check_eq("idle.valid", 32'(o_valid), 32'd0);

        // Backpressure: 1.0 held for five cycles while 2.0 waits.
        o_ready = 1'b0; i_valid = 1'b1; i_data = 16'h3C00;
        tick();
        i_data = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("bp.exp%0d", i),   32'(o_exp),   32'd15);
            check_eq($sformatf("bp.sig%0d", i),   32'(o_sig),   32'h400);
            check_eq($sformatf("bp.valid%0d", i), 32'(o_valid), 32'd1);
            check_eq($sformatf("bp.ready%0d", i), 32'(i_ready), 32'd0);
        end
        o_ready = 1'b1;
        #1;
        check_eq("bp.ready_rise", 32'(i_ready), 32'd1);
        tick();
        check_out("two", 1'b0, 7'd16, 11'h400, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        tick();

        // Reset three cycles into normalising 0x0001.
        o_ready = 1'b0; i_valid = 1'b1; i_data = 16'h0001;
        tick();
        i_valid = 1'b0;
        check_eq("mid.cnt", 32'(o_cnt), 32'd3);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mid.valid", 32'(o_valid), 32'd0);
        check_eq("mid.exp",   32'(o_exp),   32'd0);
        check_eq("mid.sig",   32'(o_sig),   32'd0);
        check_eq("mid.flags", 32'({o_sign, o_zero, o_inf, o_nan}), 32'd0);
        check_eq("mid.cnt",   32'(o_cnt),   32'd0);
        check_eq("mid.ready", 32'(i_ready), 32'd1);
        tick();
        check_eq("mid.ready2", 32'(i_ready), 32'd1);

        // Counter saturation: nine subnormals; the 3-bit copy stops at 7.
        o_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            i_valid = 1'b1; i_data = 16'h0200;
            tick();
            i_valid = 1'b0;
            tick();
            check_eq($sformatf("sat.valid%0d", i), 32'(o_valid), 32'd1);
            check_eq($sformatf("sat.exp%0d", i),   32'(o_exp),   32'd0);
            check_eq($sformatf("sat.cnt%0d", i),   32'(o_cnt),   32'(i + 1));
            check_eq($sformatf("sat.small%0d", i), 32'(sm_o_cnt), 32'((i + 1 > 7) ? 7 : i + 1));
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
